// File: rtl/cnt161_div_ctrl_pkg.sv
// Shared definitions for the 74LS161a divide-by-N controller: state encoding
// and default widths, also reused by benches that model the counter stage.
package cnt161_div_ctrl_pkg;

    // Counter stage width; the LS161a is a 4-bit part.
    localparam int CNT_W     = 4;
    // Default width of the repeat count and the wrap counter.
    localparam int REP_W_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/cnt161_div_ctrl_wrap_counter.sv
// Wrap counter: counts counter-stage wraps since the last START and flags the
// wrap that will bring the count to the requested repeat value.
module wrap_counter
    import cnt161_div_ctrl_pkg::*;
#(
    parameter int REP_W = REP_W_DEF
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             clear,
    input  logic             inc,
    input  logic [REP_W-1:0] reps,
    output logic [REP_W-1:0] wraps,
    output logic             last_wrap
);

    logic [REP_W-1:0] wraps_next;

    // Modular increment: with reps==0 the terminal wrap is the one that rolls back to 0.
    assign wraps_next = wraps + REP_W'(1);
    assign last_wrap  = (wraps_next == reps);

    // Wrap count register; clear wins over increment.
    // NOTE: sequential state is written with non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wraps <= '0;
        end else if (clear) begin
            wraps <= '0;
        end else if (inc) begin
            wraps <= wraps_next;
        end
    end

endmodule

// File: rtl/cnt161_div_ctrl.sv
// Upstream controller for an LS161a-style counter: programs it as a
// divide-by-(16-PRESET) timebase, counts wraps, one-shot or continuous.
module cnt161_div_ctrl
    import cnt161_div_ctrl_pkg::*;
#(
    parameter int CW    = CNT_W,
    parameter int REP_W = REP_W_DEF
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [CW-1:0]    preset,
    input  logic [REP_W-1:0] reps,
    input  logic [CW-1:0]    q_in,
    input  logic             rco_in,
    output logic [CW-1:0]    d,
    output logic             load_n,
    output logic             enp,
    output logic             ent,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] wraps
);

    state_t           state;
    logic [CW-1:0]    preset_q;
    logic [REP_W-1:0] reps_q;
    logic             mode_q;

    logic             go;
    logic             run_en;
    logic             wrap;
    logic             last_wrap;

    // STOP gates every action: it freezes the counter and blocks wrap accounting.
    assign go     = (state == S_IDLE) && start && !stop;
    assign run_en = (state == S_RUN) && !stop;
    assign wrap   = run_en && rco_in;

    // Counter-side decode. LOAD_n follows RCO in RUN so the counter reloads on
    // its terminal edge instead of rolling over to 0.
    assign enp    = run_en;
    assign ent    = run_en;
    assign load_n = !(((state == S_LOAD) && !stop) || wrap);
    assign busy   = (state == S_LOAD) || (state == S_RUN);
    assign d      = preset_q;

    wrap_counter #(
        .REP_W (REP_W)
    ) u_wrap_counter (
        .clk       (clk),
        .clr_n     (clr_n),
        .clear     (go),
        .inc       (wrap),
        .reps      (reps_q),
        .wraps     (wraps),
        .last_wrap (last_wrap)
    );

    // Sequencer FSM with parameter latches and registered TICK/DONE pulses.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= S_IDLE;
            preset_q <= '0;
            reps_q   <= '0;
            mode_q   <= 1'b0;
            tick     <= 1'b0;
            done     <= 1'b0;
        end else begin
            tick <= wrap;
            done <= 1'b0;
            if (stop) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            preset_q <= preset;
                            reps_q   <= reps;
                            mode_q   <= mode;
                            state    <= S_LOAD;
                        end
                    end
                    S_LOAD: state <= S_RUN;
                    S_RUN: begin
                        if (rco_in && !mode_q && last_wrap) begin
                            done  <= 1'b1;
                            state <= S_FIN;
                        end
                    end
                    S_FIN:   state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // The counter only raises RCO at its terminal count.
    a_rco_terminal: assert property (@(posedge clk) disable iff (!clr_n)
        wrap |-> (q_in == {CW{1'b1}}));

endmodule

// File: tb/tb_cnt161_div_ctrl.sv
// Bench: LS161a counter model closed in a loop with cnt161_div_ctrl, checked
// every cycle against a period-arithmetic model plus directed literal checks.
module tb_cnt161_div_ctrl;

    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_RUN  = 2;
    localparam int P_FIN  = 3;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       start, stop, mode;
    logic [3:0] preset;
    logic [7:0] reps;
    logic [3:0] d;
    logic       load_n, enp, ent, tick, busy, done;
    logic [7:0] wraps;

    // LS161a stage
    logic [3:0] cq = 4'd0;
    logic       crco;

    int n_checks = 0;
    int n_fail   = 0;
    int n_tick   = 0;
    int n_done   = 0;
    bit cmp_en   = 1'b0;

    cnt161_div_ctrl dut (
        .clk    (clk),
        .clr_n  (clr_n),
        .start  (start),
        .stop   (stop),
        .mode   (mode),
        .preset (preset),
        .reps   (reps),
        .q_in   (cq),
        .rco_in (crco),
        .d      (d),
        .load_n (load_n),
        .enp    (enp),
        .ent    (ent),
        .tick   (tick),
        .busy   (busy),
        .done   (done),
        .wraps  (wraps)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n)             cq <= 4'd0;
        else if (!load_n)       cq <= d;
        else if (enp && ent)    cq <= cq + 4'd1;
    end
    assign crco = (cq == 4'hF) && ent;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase of the run plus elapsed RUN edges; counter position, wrap
    // count and pulses follow from the period 16-PRESET.
    int         m_phase  = P_IDLE;
    int         m_cyc    = 0;
    int         m_wraps  = 0;
    int         m_period = 16;
    logic [3:0] m_q      = 4'd0;
    logic [3:0] m_preset = 4'd0;
    logic [7:0] m_reps   = 8'd0;
    logic       m_mode   = 1'b0;
    logic       m_tick   = 1'b0;
    logic       m_done   = 1'b0;

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_phase = P_IDLE; m_cyc = 0; m_wraps = 0; m_q = 4'd0;
            m_preset = 4'd0; m_reps = 8'd0; m_mode = 1'b0;
            m_tick = 1'b0; m_done = 1'b0;
        end else begin
            m_tick = 1'b0;
            m_done = 1'b0;
            if (stop) begin
                m_phase = P_IDLE;
            end else begin
                case (m_phase)
                    P_IDLE: if (start) begin
                        m_preset = preset; m_reps = reps; m_mode = mode;
                        m_wraps = 0; m_phase = P_LOAD;
                    end
                    P_LOAD: begin
                        m_q = m_preset; m_cyc = 0; m_phase = P_RUN;
                    end
                    P_RUN: begin
                        m_period = 16 - int'(m_preset);
                        m_cyc++;
                        m_q = 4'(int'(m_preset) + (m_cyc % m_period));
                        if (m_cyc % m_period == 0) begin
                            m_wraps++;
                            m_tick = 1'b1;
                            if (!m_mode && (m_cyc / m_period) == ((m_reps == 8'd0) ? 256 : int'(m_reps))) begin
                                m_done  = 1'b1;
                                m_phase = P_FIN;
                            end
                        end
                    end
                    default: m_phase = P_IDLE;
                endcase
            end
        end
    end

    logic exp_load_n, exp_en;

    always @(negedge clk) begin
        if (cmp_en) begin
            exp_en     = (m_phase == P_RUN) && !stop;
            exp_load_n = !(((m_phase == P_LOAD) && !stop) || (exp_en && m_q == 4'hF));
            check("load_n", load_n, exp_load_n);
            check("enp", enp, exp_en);
            check("ent", ent, exp_en);
            check("tick", tick, m_tick);
            check("done", done, m_done);
            check("busy", busy, (m_phase == P_LOAD) || (m_phase == P_RUN));
            check("wraps", wraps, m_wraps % 256);
            check("d", d, m_preset);
            check("q", cq, m_q);
        end
    end

    always @(negedge clk) begin
        if (tick === 1'b1) n_tick++;
        if (done === 1'b1) n_done++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int  done_at;
    bit  done_seen;

    initial begin
        clr_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
        preset = 4'd0; reps = 8'd0;
        #3;
        check("rst_load_n", load_n, 1); check("rst_enp", enp, 0);
        check("rst_ent", ent, 0);       check("rst_tick", tick, 0);
        check("rst_done", done, 0);     check("rst_busy", busy, 0);
        check("rst_wraps", wraps, 0);   check("rst_d", d, 0);
        @(posedge clk); @(posedge clk); #2;
        clr_n = 1'b1;
        cmp_en = 1'b1;

        // 1: continuous divide-by-4, with an ignored START mid-run
        preset = 4'd12; mode = 1'b1; start = 1'b1; step(); start = 1'b0;
        check("t1_load_pulse", load_n, 0);
        steps(3);
        start = 1'b1; preset = 4'd3; mode = 1'b0; reps = 8'd1; step();
        start = 1'b0; preset = 4'd12; mode = 1'b1;
        steps(9);
        check("t1_wraps", wraps, 3);
        check("t1_q", cq, 12);
        check("t1_tick", tick, 1);
        stop = 1'b1; step(); stop = 1'b0;
        check("t1_stop_busy", busy, 0);

        // 2: one-shot, 3 periods of 2
        n_tick = 0; n_done = 0;
        mode = 1'b0; preset = 4'd14; reps = 8'd3; start = 1'b1; step(); start = 1'b0;
        steps(9);
        check("t2_ticks", n_tick, 3);
        check("t2_dones", n_done, 1);
        check("t2_wraps", wraps, 3);
        check("t2_q_park", cq, 14);
        check("t2_enp", enp, 0);
        check("t2_busy", busy, 0);

        // 3: STOP with Q=13 freezes the counter
        n_tick = 0;
        mode = 1'b1; preset = 4'd10; start = 1'b1; step(); start = 1'b0;
        steps(4);
        check("t3_q_before", cq, 13);
        stop = 1'b1; step();
        check("t3_enp", enp, 0);
        check("t3_ent", ent, 0);
        check("t3_busy", busy, 0);
        stop = 1'b0;
        steps(5);
        check("t3_q_hold", cq, 13);
        check("t3_wraps", wraps, 0);
        check("t3_ticks", n_tick, 0);

        // 4: PRESET=15 divide-by-1
        n_tick = 0;
        preset = 4'd15; mode = 1'b1; start = 1'b1; step(); start = 1'b0;
        steps(6);
        check("t4_wraps", wraps, 5);
        check("t4_q", cq, 15);
        check("t4_tick", tick, 1);
        check("t4_ticks", n_tick, 4);
        stop = 1'b1; step(); stop = 1'b0;

        // 5a: START and STOP together in IDLE
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        check("t5a_busy", busy, 0);
        check("t5a_load_n", load_n, 1);
        check("t5a_wraps", wraps, 5);
        step();
        check("t5a_busy_later", busy, 0);

        // 5b: STOP on the RCO cycle of the final wrap
        n_tick = 0; n_done = 0;
        mode = 1'b0; preset = 4'd14; reps = 8'd1; start = 1'b1; step(); start = 1'b0;
        steps(2);
        check("t5b_q_term", cq, 15);
        stop = 1'b1; step(); stop = 1'b0;
        steps(3);
        check("t5b_ticks", n_tick, 0);
        check("t5b_dones", n_done, 0);
        check("t5b_wraps", wraps, 0);
        check("t5b_q_hold", cq, 15);
        check("t5b_busy", busy, 0);

        // 6: asynchronous reset mid-RUN, then REPS=0 one-shot (256 periods)
        mode = 1'b1; preset = 4'd12; start = 1'b1; step(); start = 1'b0;
        steps(5);
        check("t6_tick_pre", tick, 1);
        check("t6_wraps_pre", wraps, 1);
        #1 clr_n = 1'b0;
        #1;
        check("t6_rst_load_n", load_n, 1); check("t6_rst_enp", enp, 0);
        check("t6_rst_tick", tick, 0);     check("t6_rst_done", done, 0);
        check("t6_rst_busy", busy, 0);     check("t6_rst_wraps", wraps, 0);
        check("t6_rst_d", d, 0);           check("t6_rst_q", cq, 0);
        step();
        clr_n = 1'b1;
        n_tick = 0; n_done = 0;
        mode = 1'b0; preset = 4'd14; reps = 8'd0; start = 1'b1; step(); start = 1'b0;
        done_seen = 1'b0; done_at = 0;
        for (int i = 1; i <= 600 && !done_seen; i++) begin
            step();
            if (done === 1'b1) begin
                done_seen = 1'b1;
                done_at   = i;
            end
        end
        check("t6_done_seen", done_seen, 1);
        check("t6_done_cycle", done_at, 513);
        check("t6_wraps", wraps, 0);
        step();
        check("t6_ticks", n_tick, 256);
        check("t6_dones", n_done, 1);
        check("t6_idle", busy, 0);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
